// File: rtl/keyboard_command_scheduler.sv
// PS/2 set-2 scan-code parser feeding a 4-entry game-command FIFO.
// Tracks held keys, suppresses keyboard typematic repeats, and generates its own auto-repeat.
module keyboard_command_scheduler #(
    parameter int unsigned REPEAT_DELAY = 12_500_000,
    parameter int unsigned REPEAT_RATE  = 2_500_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       code_valid_i,
    input  logic [7:0] code_i,
    output logic       cmd_valid_o,
    output logic [2:0] cmd_o,
    input  logic       cmd_ready_i,
    output logic [5:0] held_o,
    output logic       overflow_o
);

    localparam logic [23:0] DLY = 24'(REPEAT_DELAY);
    localparam logic [23:0] RATE = 24'(REPEAT_RATE);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} pstate_e;

    pstate_e         state_q, state_d;
    logic [5:0]      held_q, held_d;
    logic [2:0]      rpt_q, rpt_d;
    logic [23:0]     tmr_q, tmr_d;
    logic [3:0][2:0] slot_q, slot_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    logic [2:0] mk_cmd, bk_cmd, push_cmd;
    logic       par_push, rpt_push, push, pop;

    // Returns 0 for anything that is not a game key with the correct E0 flag.
    function automatic logic [2:0] key_map(input logic [7:0] c, input logic ext);
        logic [2:0] k;
        k = 3'd0;
        if (ext) begin
            case (c)
                8'h6B:   k = 3'd1;
                8'h74:   k = 3'd2;
                8'h75:   k = 3'd3;
                8'h72:   k = 3'd4;
                default: k = 3'd0;
            endcase
        end else begin
            case (c)
                8'h29:   k = 3'd5;
                8'h4D:   k = 3'd6;
                default: k = 3'd0;
            endcase
        end
        return k;
    endfunction

    function automatic logic repeatable(input logic [2:0] k);
        return (k == 3'd1) || (k == 3'd2) || (k == 3'd4);
    endfunction

    always_comb begin
        state_d = state_q;
        mk_cmd  = 3'd0;
        bk_cmd  = 3'd0;
        if (code_valid_i) begin
            case (state_q)
                IDLE: begin
                    if (code_i == 8'hE0)      state_d = EXT;
                    else if (code_i == 8'hF0) state_d = BRK;
                    else                      mk_cmd  = key_map(code_i, 1'b0);
                end
                EXT: begin
                    if (code_i == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else begin
                        mk_cmd  = key_map(code_i, 1'b1);
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    bk_cmd  = key_map(code_i, 1'b0);
                    state_d = IDLE;
                end
                EXT_BRK: begin
                    bk_cmd  = key_map(code_i, 1'b1);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        held_d   = held_q;
        rpt_d    = rpt_q;
        tmr_d    = tmr_q;
        par_push = 1'b0;
        rpt_push = 1'b0;
        if (rpt_q != 3'd0) begin
            if (tmr_q == 24'd1) begin
                rpt_push = 1'b1;
                tmr_d    = RATE;
            end else begin
                tmr_d = tmr_q - 24'd1;
            end
        end
        // A make while already held is a keyboard typematic repeat and is dropped.
        if (mk_cmd != 3'd0 && !held_q[mk_cmd - 3'd1]) begin
            held_d[mk_cmd - 3'd1] = 1'b1;
            par_push              = 1'b1;
            if (repeatable(mk_cmd)) begin
                rpt_d = mk_cmd;
                tmr_d = DLY;
            end
        end
        if (bk_cmd != 3'd0 && held_q[bk_cmd - 3'd1]) begin
            held_d[bk_cmd - 3'd1] = 1'b0;
            if (bk_cmd == rpt_q) begin
                rpt_d = 3'd0;
                tmr_d = 24'd0;
            end
        end
    end

    assign push     = par_push | rpt_push;
    assign push_cmd = par_push ? mk_cmd : rpt_q;
    assign pop      = cmd_valid_o && cmd_ready_i;

    // Shift FIFO: slot 0 is the head, so cmd_o comes straight from a flop.
    always_comb begin
        slot_d = slot_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (pop) begin
            for (int i = 0; i < 3; i++) slot_d[i] = slot_q[i+1];
            slot_d[3] = 3'd0;
            cnt_d     = cnt_q - 3'd1;
        end
        if (push) begin
            if (cnt_q != 3'd4 || pop) begin
                slot_d[cnt_d[1:0]] = push_cmd;
                cnt_d              = cnt_d + 3'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            held_q  <= '0;
            rpt_q   <= '0;
            tmr_q   <= '0;
            slot_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            rpt_q   <= rpt_d;
            tmr_q   <= tmr_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cmd_o       = slot_q[0];
    assign cmd_valid_o = (slot_q[0] != 3'd0);
    assign held_o      = held_q;
    assign overflow_o  = ovf_q;

endmodule

// File: doc/keyboard_command_scheduler.md
# keyboard_command_scheduler

Sits between the PS/2 scan-code receiver and the Tetrix game logic. Parses set-2 scan-code bytes (E0 extended prefix, F0 break prefix), tracks which game keys are held, generates auto-repeat for movement keys with its own delay/rate timer, and queues game commands in a 4-entry FIFO drained by a valid/ready handshake. Keyboard typematic repeats are suppressed; all repetition comes from this block.

## Interface
- REPEAT_DELAY, 12_500_000: cycles from make to first auto-repeat (>=2)
- REPEAT_RATE, 2_500_000: cycles between subsequent auto-repeats (>=2)
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- code_valid  in  1  one-cycle strobe, code holds a received scan-code byte
- code  in  8  scan-code byte
- cmd_valid  out  1  FIFO non-empty
- cmd  out  3  head command: 1 LEFT, 2 RIGHT, 3 ROTATE, 4 SOFT_DROP, 5 HARD_DROP, 6 PAUSE; 0 when empty
- cmd_ready  in  1  consumer accepts head when cmd_valid high
- held  out  6  bit k-1 set while key for command k is held
- overflow  out  1  sticky: a command was dropped on a full FIFO

## Operation
- Key map: E0 6B LEFT, E0 74 RIGHT, E0 75 ROTATE, E0 72 SOFT_DROP, 29 HARD_DROP, 4D PAUSE. Other codes ignored.
- Parser FSM, one transition per code_valid:
  - IDLE: E0->EXT; F0->BRK; else make(code, ext=0), stay IDLE.
  - EXT: F0->EXT_BRK; else make(code, ext=1)->IDLE.
  - BRK: break(code, ext=0)->IDLE.
  - EXT_BRK: break(code, ext=1)->IDLE.
  - Extension flag must match the map; E0 29 or plain 6B do nothing.
- make of mapped key: if held bit already set -> ignored (typematic). Else set held bit, push command.
- Repeatable keys: LEFT, RIGHT, SOFT_DROP. A make of one becomes the repeat key (replaces any previous), timer loads REPEAT_DELAY.
- Timer at 1 with repeat key active: push repeat key's command, reload REPEAT_RATE.
- break: clear held bit; if it is the repeat key, timer stops, no repeat key. Break of non-held key: no effect.
- FIFO: 4 entries, push at tail, pop head when cmd_valid && cmd_ready.
- Push on full with no pop in same cycle: command dropped, overflow set. Push and pop same cycle on full: both occur, no overflow.
- Parser push and repeat push in same cycle: parser wins; repeat push discarded (not counted as overflow), timer still reloads REPEAT_RATE.
- overflow cleared only by reset.

## Timing
- Reset (rst=0 at clk edge): cmd_valid 0, cmd 0, held 0, overflow 0, parser IDLE, timer stopped, FIFO empty. Reset mid-sequence (e.g. after E0) discards partial state.
- Latency: make byte strobed at edge N -> held and cmd_valid visible after edge N (cycle N+1), cmd valid same cycle.
- First repeat push at edge N+REPEAT_DELAY, then every REPEAT_RATE edges while held.
- cmd and cmd_valid registered; cmd stable while cmd_valid && !cmd_ready.
- Pop at edge M: next entry (or cmd_valid 0) visible from M+1.
- Timer counter 24 bits; parameters must fit.

## Test plan
- Reset then codes 29, F0 29 with cmd_ready=1 -> single cmd=5 pulse, held[4] set then cleared, no repeat.
- E0 6B held 60 cycles (REPEAT_DELAY=20, REPEAT_RATE=5), then E0 F0 6B -> cmd=1 at make, then at +20,+25,...,+60; stops after break.
- E0 74 make, keyboard repeats E0 74 x3, break -> exactly one RIGHT plus timer repeats; typematic bytes produce nothing.
- cmd_ready=0, six distinct makes -> 4 entries queued in order, overflow=1; release ready -> drains 4 in order, cmd_valid falls.
- FIFO full, push and pop same cycle -> count stays 4, overflow stays 0.
- E0 then rst=0 one cycle, then 6B -> no command (plain 6B unmapped), parser IDLE; unmapped 1C make/break -> no effect.
